gc_mxr_n: RTL and testbench

N-channel mixer for good-completion (gc) update requests. It replaces the fixed two-input gc mixer on the tx path. Up to NCH gc trackers each hold a host-address update request. The block grants one request at a time with a round-robin arbiter, presents the winner's address to mem_rd on a single gc_updt/gc_updt_ack handshake, and routes the acknowledge back to the winning channel. Additions over the two-input mixer: a runtime channel-enable mask, a grant-channel indication and a completed-update counter.

---
 rtl/gc_pkg.sv | 22 ++
 rtl/gc_mxr_n_rr_pick.sv | 36 +++
 rtl/gc_mxr_n.sv | 117 +++++++++++
 tb/tb_gc_mxr_n.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared types and constants for the N-channel gc update mixer.
// Holds the FSM encoding, counter width and a width helper.
package gc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } gc_st_e;

  localparam int GC_CNT_W = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gc_mxr_n_rr_pick.sv
// Round-robin picker: first set request at or after ptr, with wrap.
// Rotates a doubled request vector down by ptr, then priority-encodes.
module rr_pick_n
  import gc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [CHW-1:0] gnt_idx,
  output logic           gnt_vld
);

  localparam logic [CHW:0] NCH_V = NCH[CHW:0];

  logic [NCH-1:0] rot;
  logic [CHW-1:0] off;
  logic [CHW:0]   sum;

  always_comb begin
    rot     = NCH'({req, req} >> ptr);
    off     = '0;
    gnt_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = CHW'(i);
        gnt_vld = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NCH_V) sum = sum - NCH_V;
    gnt_idx = sum[CHW-1:0];
  end

endmodule

// File: rtl/gc_mxr_n.sv
// N-channel good-completion update mixer toward mem_rd.
// Round-robin grant, single downstream handshake, ack routed back.
module gc_mxr_n
  import gc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 64,
  parameter int CHW = clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*AW-1:0]   gc_addr_in,
  input  logic [NCH-1:0]      gc_updt_in,
  output logic [NCH-1:0]      gc_updt_ack_in,
  input  logic [NCH-1:0]      chan_en,
  output logic [AW-1:0]       gc_addr,
  output logic                gc_updt,
  input  logic                gc_updt_ack,
  output logic [CHW-1:0]      gc_ch,
  output logic                busy,
  output logic [GC_CNT_W-1:0] gc_cnt
);

  localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

  gc_st_e                state_q, state_d;
  logic [CHW-1:0]        ptr_q, ptr_d;
  logic [CHW-1:0]        gc_ch_q, gc_ch_d;
  logic [AW-1:0]         gc_addr_q, gc_addr_d;
  logic                  gc_updt_q, gc_updt_d;
  logic [NCH-1:0]        ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [GC_CNT_W-1:0]   gc_cnt_q, gc_cnt_d;

  logic [NCH-1:0]        hold_mask;
  logic [NCH-1:0]        elig;
  logic [CHW-1:0]        pick_idx;
  logic                  pick_vld;

  // Masks the stale request level of the channel just acked.
  assign hold_mask = (state_q == RELEASE) ?
                     (NCH'(1) << gc_ch_q) : '0;
  assign elig      = gc_updt_in & chan_en & ~hold_mask;

  rr_pick_n #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_pick (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gc_ch_d   = gc_ch_q;
    gc_addr_d = gc_addr_q;
    gc_updt_d = gc_updt_q;
    ack_d     = '0;
    gc_cnt_d  = gc_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gc_ch_d   = pick_idx;
          gc_addr_d = gc_addr_in[pick_idx*AW +: AW];
          gc_updt_d = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (gc_updt_ack) begin
          gc_updt_d = 1'b0;
          ack_d     = NCH'(1) << gc_ch_q;
          gc_cnt_d  = gc_cnt_q + 1'b1;
          ptr_d     = (gc_ch_q == LAST) ? '0 :
                      gc_ch_q + CHW'(1);
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gc_ch_q   <= '0;
      gc_addr_q <= '0;
      gc_updt_q <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      gc_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gc_ch_q   <= gc_ch_d;
      gc_addr_q <= gc_addr_d;
      gc_updt_q <= gc_updt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      gc_cnt_q  <= gc_cnt_d;
    end
  end

  assign gc_addr        = gc_addr_q;
  assign gc_updt        = gc_updt_q;
  assign gc_ch          = gc_ch_q;
  assign gc_updt_ack_in = ack_q;
  assign busy           = busy_q;
  assign gc_cnt         = gc_cnt_q;

endmodule

// File: tb/tb_gc_mxr_n.sv
// Scoreboard bench for gc_mxr_n with NCH=4, AW=64.
// Directed stimulus pushes expected grants; a monitor pops and checks.
module tb_gc_mxr_n;
  import gc_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 64;
  localparam int CHW = 2;

  localparam logic [AW-1:0] A0 = 64'h0000_0000_1000_0000;
  localparam logic [AW-1:0] A1 = 64'h0000_0001_DEAD_BE00;
  localparam logic [AW-1:0] A2 = 64'hFFFF_0000_2222_2220;
  localparam logic [AW-1:0] A3 = 64'h8000_0000_0000_0038;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH*AW-1:0] gc_addr_in;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    gc_updt_ack_in;
  logic [NCH-1:0]    chan_en = '1;
  logic [AW-1:0]     gc_addr;
  logic              gc_updt;
  logic              gc_updt_ack = 1'b0;
  logic [CHW-1:0]    gc_ch;
  logic              busy;
  logic [31:0]       gc_cnt;

  int checks   = 0;
  int failures = 0;

  int             exp_q[$];
  logic           ack_pend  = 1'b0;
  logic [CHW-1:0] last_ch   = '0;
  logic           updt_prev = 1'b0;

  logic [NCH-1:0] ack_prev = '0;
  logic [NCH-1:0] regrow   = '0;
  logic           refill   = 1'b0;
  logic           ds_auto  = 1'b0;
  int             ds_delay = 0;
  int             wait_c   = 0;

  assign gc_addr_in = {A3, A2, A1, A0};

  always #5 clk = ~clk;

  gc_mxr_n #(
    .NCH (NCH),
    .AW  (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gc_addr_in     (gc_addr_in),
    .gc_updt_in     (req),
    .gc_updt_ack_in (gc_updt_ack_in),
    .chan_en        (chan_en),
    .gc_addr        (gc_addr),
    .gc_updt        (gc_updt),
    .gc_updt_ack    (gc_updt_ack),
    .gc_ch          (gc_ch),
    .busy           (busy),
    .gc_cnt         (gc_cnt)
  );

  function automatic logic [AW-1:0] addr_of(input int ch);
    case (ch)
      0:       return A0;
      1:       return A1;
      2:       return A2;
      default: return A3;
    endcase
  endfunction

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Monitor: grants against the expected queue, acks against last grant.
  always @(posedge clk) begin
    #2;
    if (gc_updt === 1'b1 && updt_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 64'(gc_ch), 64'hFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("grant_ch", 64'(gc_ch), 64'(e));
        chk("grant_addr", gc_addr, addr_of(e));
      end
      last_ch  = gc_ch;
      ack_pend = 1'b1;
    end
    if (gc_updt_ack_in !== '0) begin
      chk("ack_pending", 64'(ack_pend), 64'd1);
      chk("ack_onehot", 64'(gc_updt_ack_in),
          64'(4'b0001 << last_ch));
      ack_pend = 1'b0;
    end
    updt_prev = gc_updt;
  end

  // One cycle: upstream trackers and downstream responder.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (regrow[i]) begin
        req[i]    = 1'b1;
        regrow[i] = 1'b0;
      end
      if (ack_prev[i]) begin
        req[i] = 1'b0;
        if (refill) regrow[i] = 1'b1;
      end
    end
    ack_prev    = gc_updt_ack_in;
    gc_updt_ack = 1'b0;
    if (ds_auto && gc_updt) begin
      if (wait_c == ds_delay) begin
        gc_updt_ack = 1'b1;
        wait_c      = 0;
      end else begin
        wait_c++;
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req         = '0;
    regrow      = '0;
    refill      = 1'b0;
    ack_prev    = '0;
    wait_c      = 0;
    gc_updt_ack = 1'b0;
    chan_en     = '1;
    exp_q.delete();
    ack_pend    = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_updt(input string nm);
    int n;
    n = 0;
    while (gc_updt !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (gc_updt !== 1'b1) chk(nm, 64'(gc_updt), 64'd1);
  endtask

  task automatic wait_cnt(input string nm, input int tgt);
    int n;
    n = 0;
    while (gc_cnt !== 32'(tgt) && n < 60) begin
      step();
      n++;
    end
    chk(nm, 64'(gc_cnt), 64'(tgt));
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ack_pend) && n < 60) begin
      step();
      n++;
    end
    chk(nm, 64'(exp_q.size()) + 64'(ack_pend), 64'd0);
    repeat (4) step();
  endtask

  initial begin
    // 1: held reset with a pending request, then release
    rst    = 1'b0;
    req[2] = 1'b1;
    repeat (3) step();
    chk("rst_updt", 64'(gc_updt), 64'd0);
    chk("rst_cnt", 64'(gc_cnt), 64'd0);
    chk("rst_ack", 64'(gc_updt_ack_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", gc_addr, 64'd0);
    chk("rst_ch", 64'(gc_ch), 64'd0);
    exp_q.push_back(2);
    ds_auto  = 1'b1;
    ds_delay = 3;
    rst      = 1'b1;
    step();
    step();
    chk("t1_updt", 64'(gc_updt), 64'd1);
    chk("t1_ch", 64'(gc_ch), 64'd2);
    chk("t1_addr", gc_addr, A2);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_drain("t1_drain");
    chk("t1_cnt", 64'(gc_cnt), 64'd1);

    // 2: single request, ack three cycles late, no re-grant
    do_reset();
    ds_delay = 3;
    exp_q.push_back(1);
    req[1] = 1'b1;
    wait_drain("t2_drain");
    chk("t2_cnt", 64'(gc_cnt), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);

    // 3: all channels continuously, immediate ack
    do_reset();
    ds_delay = 0;
    refill   = 1'b1;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{0, 1, 2, 3, 0, 1};
    req   = '1;
    repeat (18) step();
    chk("t3_cnt18", 64'(gc_cnt), 64'd6);
    chk("t3_left", 64'(exp_q.size()), 64'd0);
    refill = 1'b0;
    req    = '0;
    regrow = '0;
    wait_drain("t3_drain");

    // 4: channel 2 masked, then re-enabled
    do_reset();
    refill  = 1'b1;
    chan_en = 4'b1011;
    exp_q   = '{0, 1, 3, 0, 1, 2};
    req     = '1;
    wait_cnt("t4_cnt4", 4);
    chan_en = 4'b1111;
    wait_cnt("t4_cnt6", 6);
    refill = 1'b0;
    req    = '0;
    regrow = '0;
    wait_drain("t4_drain");

    // 5: enable drops mid-grant; spurious ack while idle
    do_reset();
    ds_auto = 1'b0;
    exp_q.push_back(3);
    req[3] = 1'b1;
    wait_updt("t5_wait");
    chan_en[3] = 1'b0;
    step();
    step();
    chk("t5_hold_updt", 64'(gc_updt), 64'd1);
    chk("t5_hold_ch", 64'(gc_ch), 64'd3);
    gc_updt_ack = 1'b1;
    step();
    chk("t5_ack", 64'(gc_updt_ack_in), 64'b1000);
    chk("t5_cnt", 64'(gc_cnt), 64'd1);
    repeat (3) step();
    gc_updt_ack = 1'b1;
    step();
    chk("t5_spur_ack", 64'(gc_updt_ack_in), 64'd0);
    chk("t5_spur_cnt", 64'(gc_cnt), 64'd1);
    chk("t5_spur_updt", 64'(gc_updt), 64'd0);
    step();
    chan_en = '1;

    // 6: reset mid-grant, pointer reset, counter wrap
    do_reset();
    exp_q.push_back(2);
    req[2] = 1'b1;
    wait_updt("t6_wait_a");
    gc_updt_ack = 1'b1;
    step();
    repeat (2) step();
    exp_q.push_back(1);
    req[1] = 1'b1;
    wait_updt("t6_wait_b");
    rst = 1'b0;
    step();
    chk("t6_rst_updt", 64'(gc_updt), 64'd0);
    chk("t6_rst_ack", 64'(gc_updt_ack_in), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cnt", 64'(gc_cnt), 64'd0);
    ack_pend = 1'b0;
    req      = '0;
    exp_q.delete();
    exp_q    = '{1, 3};
    rst      = 1'b1;
    req      = 4'b1010;
    step();
    chk("t6_ptr0_ch", 64'(gc_ch), 64'd1);
    gc_updt_ack = 1'b1;
    step();
    step();
    step();
    chk("t6_ch3", 64'(gc_ch), 64'd3);
    force dut.gc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.gc_cnt_q;
    #1;
    chk("t6_preset", 64'(gc_cnt), 64'hFFFF_FFFF);
    gc_updt_ack = 1'b1;
    step();
    chk("t6_wrap", 64'(gc_cnt), 64'd0);
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
